// File: rtl/glacier_pkg.sv
// Shared types and constants for the glacier spawn scheduler.
// The LFSR constants are consumed only when GLACIER_SPAWN_LFSR_EN is defined.
package glacier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    SPAWN,
    DONE
  } state_t;

  localparam logic [15:0] DEF_SPAWN_X = 16'd876;
  localparam logic [15:0] DEF_SPAWN_Y = 16'd96;
  localparam logic [15:0] DEF_Y_LIMIT = 16'd500;

  // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/glacier_spawn_scheduler_if.sv
// Frame-control inputs and per-slot sprite outputs of the glacier scheduler.
// The master side drives V-sync and enable; the slave is the scheduler.
interface glacier_spawn_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                   i_v_sync;
  logic                   i_enable;
  logic [16*NUM_SLOTS-1:0] o_sprite_x;
  logic [16*NUM_SLOTS-1:0] o_sprite_y;
  logic [NUM_SLOTS-1:0]   o_active;
  logic                   o_busy;
  logic                   o_frame_done;
  logic                   o_spawn_drop;

  modport master (
    output i_v_sync, i_enable,
    input  o_sprite_x, o_sprite_y, o_active, o_busy, o_frame_done, o_spawn_drop
  );

  modport slave (
    input  i_v_sync, i_enable,
    output o_sprite_x, o_sprite_y, o_active, o_busy, o_frame_done, o_spawn_drop
  );
endinterface

// File: rtl/glacier_spawn_scheduler_vsync_edge_det.sv
// V-sync rising-edge detector. The delay register resets to 1 so a V-sync
// already high when reset releases is not mistaken for a new frame.
module vsync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_edge
);
  logic r_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_d <= 1'b1;
    else       r_d <= i_sig;
  end

  assign o_edge = i_sig & ~r_d;
endmodule

// File: rtl/glacier_spawn_scheduler.sv
// Per-frame glacier sprite scheduler: walks all slots once per V-sync, then spawns.
// Optional macro GLACIER_SPAWN_LFSR_EN adds a pseudo-random 0..255 offset to spawn X.
module glacier_spawn_scheduler
  import glacier_pkg::*;
#(
  parameter int          NUM_SLOTS    = 4,
  parameter int          SPAWN_PERIOD = 90,
  parameter logic [15:0] STEP         = 16'd1,
  parameter logic [15:0] Y_LIMIT      = DEF_Y_LIMIT,
  parameter logic [15:0] SPAWN_X      = DEF_SPAWN_X,
  parameter logic [15:0] SPAWN_Y      = DEF_SPAWN_Y
) (
  input logic i_clk,
  input logic i_rst,
  glacier_spawn_scheduler_if.slave bus
);

  localparam logic [15:0] CNT_RELOAD = 16'(SPAWN_PERIOD - 1);
  localparam logic [3:0]  LAST_IDX   = 4'(NUM_SLOTS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [3:0]           r_idx;
  logic [15:0]          r_cnt;
  logic [NUM_SLOTS-1:0] r_active;
  logic [15:0]          r_x [NUM_SLOTS];
  logic [15:0]          r_y [NUM_SLOTS];
  logic                 w_edge;
  logic                 w_free_found;
  logic [3:0]           w_free_idx;
  logic                 w_spawn_due;
  logic [15:0]          w_spawn_x;

  vsync_edge_det u_vsync (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (bus.i_v_sync),
    .o_edge (w_edge)
  );

`ifdef GLACIER_SPAWN_LFSR_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst)                r_lfsr <= LFSR_SEED;
    else if (r_state == DONE) r_lfsr <= lfsr_next(r_lfsr);
  end

  assign w_spawn_x = SPAWN_X + {8'h00, r_lfsr[7:0]};
`else
  assign w_spawn_x = SPAWN_X;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_edge && bus.i_enable) w_next_state = UPDATE;
      UPDATE:  if (r_idx == LAST_IDX)      w_next_state = SPAWN;
      SPAWN:   w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Scanning downwards leaves the lowest-index free slot selected.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!r_active[k]) begin
        w_free_found = 1'b1;
        w_free_idx   = 4'(k);
      end
    end
  end

  assign w_spawn_due = (r_state == SPAWN) && (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_cnt    <= CNT_RELOAD;
      r_active <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
      end
    end else begin
      case (r_state)
        UPDATE: begin
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (r_idx == 4'(k) && r_active[k]) begin
              if (r_y[k] > Y_LIMIT) begin
                r_active[k] <= 1'b0;
              end else begin
                r_x[k] <= r_x[k] + STEP;
                r_y[k] <= r_y[k] + STEP;
              end
            end
          end
          r_idx <= r_idx + 4'd1;
        end
        SPAWN: begin
          r_idx <= '0;
          if (w_spawn_due) begin
            r_cnt <= CNT_RELOAD;
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (w_free_found && w_free_idx == 4'(k)) begin
                r_active[k] <= 1'b1;
                r_x[k]      <= w_spawn_x;
                r_y[k]      <= SPAWN_Y;
              end
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_SLOTS; k++) begin
      bus.o_sprite_x[16*k +: 16] = r_x[k];
      bus.o_sprite_y[16*k +: 16] = r_y[k];
    end
    bus.o_active     = r_active;
    bus.o_busy       = (r_state != IDLE);
    bus.o_frame_done = (r_state == DONE);
    bus.o_spawn_drop = w_spawn_due && !w_free_found;
  end

endmodule

// File: tb/tb_glacier_spawn_scheduler.sv
// Self-checking bench for glacier_spawn_scheduler: a schedule table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_glacier_spawn_scheduler;
  import glacier_pkg::*;

  localparam int NS     = 4;
  localparam int PERIOD = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  glacier_spawn_scheduler_if #(.NUM_SLOTS(NS)) bus ();

  glacier_spawn_scheduler #(
    .NUM_SLOTS    (NS),
    .SPAWN_PERIOD (PERIOD),
    .STEP         (16'd1),
    .Y_LIMIT      (16'd500),
    .SPAWN_X      (16'd876),
    .SPAWN_Y      (16'd96)
  ) dut (
    .i_clk (clock),
    .i_rst (reset),
    .bus   (bus.slave)
  );

  int nCompared   = 0;
  int nMismatched = 0;

  // Frame-level reference model
  logic [15:0] mX [NS];
  logic [15:0] mY [NS];
  bit          mAct [NS];
  int          mCnt;
  logic [15:0] mLfsr;

  typedef struct {
    logic [3:0] expActive;
    bit         expDrop;
  } vec_t;
  vec_t schedTable [15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NS; k++) begin
      mX[k] = '0; mY[k] = '0; mAct[k] = 0;
    end
    mCnt  = PERIOD - 1;
    mLfsr = LFSR_SEED;
  endtask

  task automatic modelFrame(output bit drop);
    bit found;
    logic [15:0] sx;
    drop = 0;
    for (int k = 0; k < NS; k++) begin
      if (mAct[k]) begin
        if (int'(mY[k]) > 500) mAct[k] = 0;
        else begin
          mX[k] = mX[k] + 16'd1;
          mY[k] = mY[k] + 16'd1;
        end
      end
    end
`ifdef GLACIER_SPAWN_LFSR_EN
    sx = 16'd876 + {8'h00, mLfsr[7:0]};
    mLfsr = {mLfsr[14:0], mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
`else
    sx = 16'd876;
`endif
    if (mCnt == 0) begin
      mCnt  = PERIOD - 1;
      found = 0;
      for (int k = 0; k < NS; k++) begin
        if (!found && !mAct[k]) begin
          found = 1; mAct[k] = 1; mX[k] = sx; mY[k] = 16'd96;
        end
      end
      drop = !found;
    end else begin
      mCnt--;
    end
  endtask

  task automatic checkSlots(input string tag);
    for (int k = 0; k < NS; k++) begin
      checkOutput($sformatf("%s_x%0d", tag, k), {16'h0, bus.o_sprite_x[16*k +: 16]}, {16'h0, mX[k]});
      checkOutput($sformatf("%s_y%0d", tag, k), {16'h0, bus.o_sprite_y[16*k +: 16]}, {16'h0, mY[k]});
      checkOutput($sformatf("%s_act%0d", tag, k), {31'h0, bus.o_active[k]}, {31'h0, mAct[k]});
    end
  endtask

  // One V-sync frame; edge cycle N starts at the first negedge, cycle N+c follows.
  task automatic applyStimulus(input bit busyEdge, output bit sawDrop);
    bit expDrop;
    modelFrame(expDrop);
    sawDrop = 0;
    @(negedge clock);
    bus.i_v_sync = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      checkOutput($sformatf("busy_c%0d", c), {31'h0, bus.o_busy}, {31'h0, (c <= 6)});
      checkOutput($sformatf("done_c%0d", c), {31'h0, bus.o_frame_done}, {31'h0, (c == 6)});
      checkOutput($sformatf("drop_c%0d", c), {31'h0, bus.o_spawn_drop}, {31'h0, (c == 5) && expDrop});
      if (bus.o_spawn_drop) sawDrop = 1;
      if (c == 1) bus.i_v_sync = 1'b0;
      if (busyEdge && c == 3) bus.i_v_sync = 1'b1;
      if (busyEdge && c == 4) bus.i_v_sync = 1'b0;
    end
    checkSlots("frame");
  endtask

  task automatic disabledEdge();
    @(negedge clock);
    bus.i_enable = 1'b0;
    bus.i_v_sync = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      checkOutput("dis_busy", {31'h0, bus.o_busy}, 32'd0);
      checkOutput("dis_done", {31'h0, bus.o_frame_done}, 32'd0);
      bus.i_v_sync = 1'b0;
    end
    checkSlots("dis");
    bus.i_enable = 1'b1;
  endtask

  task automatic idleGap(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      checkOutput("idle_busy", {31'h0, bus.o_busy}, 32'd0);
      checkOutput("idle_done", {31'h0, bus.o_frame_done}, 32'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawDrop;
    int guard;

    for (int i = 0; i < 15; i++) begin
      int f;
      f = i + 1;
      schedTable[i].expActive = (f < 3) ? 4'b0000 : (f < 6) ? 4'b0001 :
                                (f < 9) ? 4'b0011 : (f < 12) ? 4'b0111 : 4'b1111;
      schedTable[i].expDrop   = (f == 15);
    end

    // V-sync held high across reset release must not start a walk
    bus.i_v_sync = 1'b1;
    bus.i_enable = 1'b1;
    modelReset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checkOutput("rst_busy", {31'h0, bus.o_busy}, 32'd0);
      checkOutput("rst_active", {28'h0, bus.o_active}, 32'd0);
      checkOutput("rst_x", bus.o_sprite_x[31:0], 32'd0);
      checkOutput("rst_y", bus.o_sprite_y[31:0], 32'd0);
    end
    bus.i_v_sync = 1'b0;
    idleGap(2);

    // Spawn schedule from reset, filling slots 0..3 then dropping
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, sawDrop);
      checkOutput($sformatf("tbl_active_f%0d", i + 1), {28'h0, bus.o_active}, {28'h0, schedTable[i].expActive});
      checkOutput($sformatf("tbl_drop_f%0d", i + 1), {31'h0, sawDrop}, {31'h0, schedTable[i].expDrop});
`ifndef GLACIER_SPAWN_LFSR_EN
      if (i + 1 >= 3) begin
        checkOutput("tbl_x0", {16'h0, bus.o_sprite_x[15:0]}, 32'(876 + (i + 1 - 3)));
        checkOutput("tbl_y0", {16'h0, bus.o_sprite_y[15:0]}, 32'(96 + (i + 1 - 3)));
      end
`endif
      idleGap(1);
    end

    // Randomized frames, ignored edges and gaps until slot0 reaches Y=500
    guard = 0;
    while (!(mAct[0] && mY[0] == 16'd500) && guard < 600) begin
      if ($urandom_range(0, 4) == 0) disabledEdge();
      applyStimulus(1'($urandom_range(0, 1)), sawDrop);
      idleGap($urandom_range(0, 3));
      guard++;
    end
    checkOutput("reach_y500", {16'h0, bus.o_sprite_y[15:0]}, 32'd500);

    applyStimulus(1'b0, sawDrop);
    checkOutput("y501_y0", {16'h0, bus.o_sprite_y[15:0]}, 32'd501);
    checkOutput("y501_act0", {31'h0, bus.o_active[0]}, 32'd1);

    applyStimulus(1'b0, sawDrop);
    checkOutput("retire_act0", {31'h0, bus.o_active[0]}, 32'd0);
    checkOutput("retire_y0", {16'h0, bus.o_sprite_y[15:0]}, 32'd501);
`ifndef GLACIER_SPAWN_LFSR_EN
    checkOutput("retire_x0", {16'h0, bus.o_sprite_x[15:0]}, 32'd1281);
`endif

    applyStimulus(1'b0, sawDrop);
    applyStimulus(1'b0, sawDrop);
    checkOutput("reuse_act0", {31'h0, bus.o_active[0]}, 32'd1);
    checkOutput("reuse_y0", {16'h0, bus.o_sprite_y[15:0]}, 32'd96);
`ifndef GLACIER_SPAWN_LFSR_EN
    checkOutput("reuse_x0", {16'h0, bus.o_sprite_x[15:0]}, 32'd876);
`endif
    idleGap(2);

    // Reset while slot1 is being updated aborts the walk
    @(negedge clock);
    bus.i_v_sync = 1'b1;
    @(negedge clock);
    bus.i_v_sync = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort_busy", {31'h0, bus.o_busy}, 32'd0);
    checkOutput("abort_done", {31'h0, bus.o_frame_done}, 32'd0);
    checkOutput("abort_active", {28'h0, bus.o_active}, 32'd0);
    checkOutput("abort_x", bus.o_sprite_x[63:32], 32'd0);
    checkOutput("abort_y", bus.o_sprite_y[31:0], 32'd0);
    reset = 1'b0;
    modelReset();
    idleGap(1);

    // Counter restarted at PERIOD-1: only the third frame spawns
    for (int f = 1; f <= 3; f++) begin
      applyStimulus(1'b0, sawDrop);
      checkOutput($sformatf("post_rst_active_f%0d", f), {28'h0, bus.o_active}, (f == 3) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/glacier_spawn_scheduler.md
Name: glacier_spawn_scheduler

Overview:
Per-frame scheduler that owns position and lifetime for a pool of glacier sprite slots. Each sprite renderer is driven by one slot's X/Y and active flag. On each V-sync rising edge the block walks all slots one per clock, advancing or retiring each. It then spawns a new glacier into a free slot on a frame-count schedule. This replaces free-running per-sprite motion logic with one sequenced controller in the pixel clock domain.

Parameters:
NUM_SLOTS, 4, number of sprite slots (1..8)
SPAWN_PERIOD, 90, frames between spawn attempts (>=1)
STEP, 1, pixels added to X and Y per frame for an active slot
Y_LIMIT, 500, a slot whose Y is strictly greater than this at update time is retired
SPAWN_X, 876, X of a newly spawned slot (top-left)
SPAWN_Y, 96, Y of a newly spawned slot (top-left)

Ports:
i_clk  in  1  pixel clock; the only clock
i_rst  in  1  reset, synchronous, active-high
i_v_sync  in  1  vertical sync, synchronous to i_clk; rising edge = new frame
i_enable  in  1  1 = process frames; 0 = frozen
o_sprite_x  out  16*NUM_SLOTS  packed X per slot; slot k at bits [16k+15:16k]
o_sprite_y  out  16*NUM_SLOTS  packed Y per slot, same packing
o_active  out  NUM_SLOTS  per-slot active flag
o_busy  out  1  high while the frame walk is in progress (state != IDLE)
o_frame_done  out  1  one-cycle pulse when a frame walk completes
o_spawn_drop  out  1  one-cycle pulse when a due spawn finds no free slot

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge): state=IDLE; all o_active=0; all X/Y=0; o_busy=0; o_frame_done=0; o_spawn_drop=0; spawn counter=SPAWN_PERIOD-1. The V-sync delay register resets to 1, so a V-sync held high across reset release produces no edge.
- Edge detect: vs_d<=i_v_sync every cycle; edge = i_v_sync & ~vs_d.
- FSM states: IDLE, UPDATE, SPAWN, DONE.
- IDLE -> UPDATE when edge & i_enable. Edges are ignored when i_enable=0 or state!=IDLE; they are not queued.
- UPDATE: slot index k runs 0..NUM_SLOTS-1, one slot per cycle.
  - Active slot with Y > Y_LIMIT: cleared to inactive; X/Y held.
  - Otherwise an active slot gets X+=STEP and Y+=STEP, modulo 2^16 with no saturation.
  - Inactive slots are unchanged.
  - After the last slot the FSM goes to SPAWN.
- SPAWN, counter != 0: counter decrements.
- SPAWN, counter == 0: counter reloads SPAWN_PERIOD-1. The lowest-index inactive slot becomes active with X=SPAWN_X, Y=SPAWN_Y. If no slot is free, o_spawn_drop pulses in this cycle.
- A slot retired in the same frame's UPDATE counts as free.
- SPAWN -> DONE. DONE: o_frame_done=1 for one cycle, then IDLE.
- Latency: for an edge seen in cycle N, slot k is updated at the clock ending cycle N+1+k. SPAWN occurs in cycle N+1+NUM_SLOTS, DONE in N+2+NUM_SLOTS, and IDLE in N+3+NUM_SLOTS.
- o_busy=1 from cycle N+1 through DONE inclusive.
- Outputs change only at UPDATE/SPAWN clock edges and are stable otherwise.
- Reset mid-walk aborts the walk immediately and applies the reset values; there is no partial-frame completion.

Optional Feature:
GLACIER_SPAWN_LFSR_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset; never zero) steps once per DONE. Spawn X becomes SPAWN_X + lfsr[7:0] (0..255 offset, 16-bit add).
- Undefined: no LFSR; spawn X is exactly SPAWN_X.
- Y, timing and all other behaviour are identical in both builds.

Decomposition:
- Package glacier_pkg: FSM state enum (IDLE, UPDATE, SPAWN, DONE); default spawn coordinates; Y_LIMIT default; LFSR seed and tap constants.
- One sub-module: vsync_edge_det (register plus rising-edge pulse, reset value 1). The slot array and FSM stay in the top.

Test Plan:
Common setup: NUM_SLOTS=4, SPAWN_PERIOD=3, STEP=1, SPAWN_X=876, SPAWN_Y=96, Y_LIMIT=500, LFSR off.
1. Hold i_v_sync=1 through reset release -> no walk starts, o_busy=0, o_active=4'b0000.
2. Send 3 V-sync pulses, edge at cycle N -> after frame 3, o_active=4'b0001 and slot0 (X,Y)=(876,96). o_frame_done is high only in cycle N+6 and o_busy is high in cycles N+1..N+6.
3. Send 15 frames with no retirement -> spawns land at frames 3, 6, 9 and 12 into slots 0..3. At frame 15, o_spawn_drop pulses once and o_active stays 4'b1111.
4. Drive slot0 to Y=500, then one frame -> Y=501, still active. Next frame -> slot0 inactive, X/Y held. A spawn due that frame reuses slot0.
5. Send an edge while o_busy=1, or with i_enable=0 -> no state, counter or output change, and no o_frame_done.
6. Assert i_rst in the cycle slot1 is being updated -> next cycle state=IDLE, o_active=0, all X/Y=0, counter=2.
